// File: rtl/controller_core.sv
// controller_core: PC, IR and control FSM of a 16-bit processor.
// Ports: Clk/Rst (async active-high); Inst = ROM word for address PC_out;
// IR_out/OutState/NextState = debug; D_addr/D_wr = data memory;
// RF_s/RF_W_addr/RF_W_en/RF_Ra_addr/RF_Rb_addr = register file; Alu_s0 = ALU op.
module controller_core (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Inst,
  output logic [6:0]  PC_out,
  output logic [15:0] IR_out,
  output logic [3:0]  OutState,
  output logic [3:0]  NextState,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  Alu_s0
);
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOP    = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;
  state_t      state_q, state_d;
  logic [6:0]  pc_q;
  logic [15:0] ir_q;
  logic        pc_clr, pc_up, ir_ld, is_load, is_alu;
  assign pc_clr  = state_q == S_INIT;
  assign pc_up   = state_q == S_FETCH;
  assign ir_ld   = state_q == S_FETCH;
  assign is_load = state_q == S_LOADA || state_q == S_LOADB;
  assign is_alu  = state_q == S_ADD || state_q == S_SUB;
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE:
        case (ir_q[15:12])
          4'd1:    state_d = S_LOADA;
          4'd2:    state_d = S_STORE;
          4'd3:    state_d = S_ADD;
          4'd4:    state_d = S_SUB;
          4'd5:    state_d = S_HALT;
          default: state_d = S_NOP;
        endcase
      S_LOADA:  state_d = S_LOADB;
      S_LOADB, S_NOP, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_INIT;
      pc_q    <= 7'd0;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      if (pc_clr) pc_q <= 7'd0;
      else if (pc_up) pc_q <= pc_q + 7'd1;
      if (ir_ld) ir_q <= Inst;
    end
  end
  assign PC_out     = pc_q;
  assign IR_out     = ir_q;
  assign OutState   = state_q;
  assign NextState  = state_d;
  // Outputs decode from the state register, so an async reset clears them at once
  assign D_addr     = (is_load || state_q == S_STORE) ? ir_q[11:4] : 8'd0;
  assign D_wr       = state_q == S_STORE;
  assign RF_s       = is_load;
  assign RF_W_addr  = (is_load || is_alu) ? ir_q[3:0] : 4'd0;
  assign RF_W_en    = state_q == S_LOADB || is_alu;
  assign RF_Ra_addr = state_q == S_STORE ? ir_q[3:0] : is_alu ? ir_q[11:8] : 4'd0;
  assign RF_Rb_addr = is_alu ? ir_q[7:4] : 4'd0;
  assign Alu_s0     = state_q == S_ADD ? 3'b001 : state_q == S_SUB ? 3'b010 : 3'b000;
endmodule

// File: tb/tb_controller_core.sv
// tb_controller_core: random-program check of controller_core against an instruction-level model.
module tb_controller_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst = 16'd0;
  logic [6:0]  pc_out;
  logic [15:0] ir_out;
  logic [3:0]  out_state, next_state;
  logic [7:0]  d_addr;
  logic        d_wr, rf_s, rf_w_en;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_s0;
  logic [15:0] rom [128];
  logic [25:0] ctl_obs;
  logic [3:0]  nxt_obs;
  int          n_cmp = 0, n_bad = 0;
  int          pc_m;
  logic [15:0] ir_m;
  bit          halted;
  controller_core dut (
    .Clk(clk), .Rst(rst), .Inst(inst), .PC_out(pc_out), .IR_out(ir_out),
    .OutState(out_state), .NextState(next_state), .D_addr(d_addr), .D_wr(d_wr),
    .RF_s(rf_s), .RF_W_addr(rf_w_addr), .RF_W_en(rf_w_en),
    .RF_Ra_addr(rf_ra_addr), .RF_Rb_addr(rf_rb_addr), .Alu_s0(alu_s0)
  );
  always #5 clk = ~clk;
  always @(posedge clk) inst <= rom[pc_out];
  assign ctl_obs = {d_addr, d_wr, rf_s, rf_w_addr, rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0};
  function automatic logic [25:0] ctl(input logic [7:0] da, input logic wr, input logic s,
                                      input logic [3:0] wa, input logic we, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [2:0] alu);
    return {da, wr, s, wa, we, ra, rb, alu};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input int st, input logic [25:0] ctl_e);
    @(posedge clk);
    #2;
    check("next_state", nxt_obs, st);
    check("state", out_state, st);
    check("pc", pc_out, pc_m);
    check("ir", ir_out, ir_m);
    check("ctl", ctl_obs, ctl_e);
    nxt_obs = next_state;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, out_state, 0);
    check({tag, "_next"}, next_state, 1);
    check({tag, "_pc"}, pc_out, 0);
    check({tag, "_ir"}, ir_out, 0);
    check({tag, "_ctl"}, ctl_obs, 0);
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    pc_m = 0;
    ir_m = 16'd0;
    halted = 0;
    #1;
    check_reset_vals("init");
    nxt_obs = next_state;
  endtask
  // One whole instruction: Fetch, Decode, then the op-specific execute cycles
  task automatic run_instr();
    logic [15:0] w;
    w = rom[pc_m];
    step(1, '0);
    ir_m = w;
    pc_m = (pc_m + 1) % 128;
    step(2, '0);
    case (w[15:12])
      4'd1: begin
        step(4, ctl(w[11:4], 0, 1, w[3:0], 0, 0, 0, 0));
        step(5, ctl(w[11:4], 0, 1, w[3:0], 1, 0, 0, 0));
      end
      4'd2: step(6, ctl(w[11:4], 1, 0, 0, 0, w[3:0], 0, 0));
      4'd3: step(7, ctl(0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b001));
      4'd4: step(8, ctl(0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b010));
      4'd5: begin
        step(9, '0);
        halted = 1;
      end
      default: step(3, '0);
    endcase
  endtask
  task automatic abort_in(input logic [15:0] w, input string tag);
    rom[0] = w;
    release_rst();
    run_instr();
    #2 rst = 1'b1;
    #1;
    check_reset_vals(tag);
  endtask
  function automatic logic [15:0] rand_word();
    logic [31:0] r;
    int op;
    r  = $urandom();
    op = $urandom_range(0, 14);
    if (op >= 5) op++;
    return {op[3:0], r[11:0]};
  endfunction
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 16'd0;
    rom[0] = 16'h3123;
    rom[1] = 16'h10A5;
    rom[2] = 16'h2FF7;
    rom[3] = 16'h4456;
    rom[4] = 16'hF000;
    for (int i = 5; i < 40; i++) rom[i] = rand_word();
    rom[40] = 16'h5000;
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("reset");
    release_rst();
    for (int n = 0; n < 60 && !halted; n++) run_instr();
    check("halt_reached", {31'd0, halted}, 1);
    repeat (5) step(9, '0);
    check("halt_pc", pc_out, 41);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("halt_rst");
    abort_in(16'h3123, "abort_add");
    abort_in(16'h2FF7, "abort_store");
    abort_in(16'h10A5, "abort_load");
    for (int i = 0; i < 128; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 16'hF000 | 16'($urandom_range(0, 4095)) : 16'h0000;
    release_rst();
    for (int n = 0; n < 130; n++) run_instr();
    check("wrap_pc", pc_out, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
